// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding,
// RV32I load/store funct3 codes and the datapath width.
package dmem_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/dmem_align.sv
// Byte-lane steering for RV32I loads and stores: store lane enables and
// replicated write data, load extraction with sign/zero extension.
module dmem_align
  import dmem_pkg::*;
(
  input  logic [2:0]      i_funct3,
  input  logic [1:0]      i_addr_lo,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [XLEN-1:0] i_rword,
  output logic [3:0]      o_lane_en,
  output logic [XLEN-1:0] o_wdata_lanes,
  output logic [XLEN-1:0] o_rdata,
  output logic            o_misaligned
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned and no latch is inferred.
    o_lane_en     = '0;
    o_wdata_lanes = '0;
    o_misaligned  = 1'b0;
    case (i_funct3[1:0])
      2'b00: begin
        o_lane_en     = 4'b0001 << i_addr_lo;
        o_wdata_lanes = {4{i_wdata[7:0]}};
      end
      2'b01: begin
        o_lane_en     = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata_lanes = {2{i_wdata[15:0]}};
        o_misaligned  = i_addr_lo[0];
      end
      2'b10: begin
        o_lane_en     = 4'b1111;
        o_wdata_lanes = i_wdata;
        o_misaligned  = |i_addr_lo;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_byte = '0;
    case (i_addr_lo)
      2'd0: w_byte = i_rword[7:0];
      2'd1: w_byte = i_rword[15:8];
      2'd2: w_byte = i_rword[23:16];
      2'd3: w_byte = i_rword[31:24];
      default: ;
    endcase
    w_half = i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0];

    o_rdata = '0;
    case (i_funct3)
      F3_B:    o_rdata = {{24{w_byte[7]}}, w_byte};
      F3_H:    o_rdata = {{16{w_half[15]}}, w_half};
      F3_W:    o_rdata = i_rword;
      F3_BU:   o_rdata = {24'd0, w_byte};
      F3_HU:   o_rdata = {16'd0, w_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder for the core's load/store unit: one outstanding
// request, fixed-latency response, RV32I sub-word access and fault flagging.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [XLEN-1:0] req_addr,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((LATENCY > 1) ? LATENCY - 2 : 0);

  state_t          r_state;
  logic [CNT_W-1:0] r_cnt;
  logic            r_we;
  logic [XLEN-1:0] r_addr;
  logic [2:0]      r_funct3;
  logic [XLEN-1:0] r_wdata;
  logic [XLEN-1:0] r_rdata;
  logic            r_err;
  logic [XLEN-1:0] r_mem [DEPTH_WORDS];

  logic            w_in_idle;
  logic            w_accept;
  logic            w_do_access;
  logic            w_acc_we;
  logic [XLEN-1:0] w_acc_addr;
  logic [2:0]      w_acc_funct3;
  logic [XLEN-1:0] w_acc_wdata;
  logic [IDX_W-1:0] w_idx;
  logic            w_out_of_range;
  logic            w_illegal;
  logic            w_misaligned;
  logic            w_err;
  logic [3:0]      w_lane_en;
  logic [XLEN-1:0] w_wdata_lanes;
  logic [XLEN-1:0] w_load_data;
  logic [XLEN-1:0] w_resp_data;

  // With LATENCY=1 the access happens on the acceptance edge itself, so the
  // datapath sees the live request in IDLE and the latched copy otherwise.
  assign w_in_idle    = (r_state == ST_IDLE);
  assign w_accept     = w_in_idle & req_valid;
  assign w_acc_we     = w_in_idle ? req_we     : r_we;
  assign w_acc_addr   = w_in_idle ? req_addr   : r_addr;
  assign w_acc_funct3 = w_in_idle ? req_funct3 : r_funct3;
  assign w_acc_wdata  = w_in_idle ? req_wdata  : r_wdata;
  assign w_do_access  = (LATENCY == 1) ? w_accept
                                       : ((r_state == ST_WAIT) && (r_cnt == '0));

  assign w_idx          = w_acc_addr[IDX_W+1:2];
  assign w_out_of_range = |w_acc_addr[XLEN-1:IDX_W+2];
  assign w_illegal      = w_acc_we
      ? !(w_acc_funct3 inside {F3_B, F3_H, F3_W})
      : !(w_acc_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
  assign w_err          = w_illegal | w_misaligned | w_out_of_range;
  assign w_resp_data    = (w_err || w_acc_we) ? '0 : w_load_data;

  dmem_align u_align (
    .i_funct3      (w_acc_funct3),
    .i_addr_lo     (w_acc_addr[1:0]),
    .i_wdata       (w_acc_wdata),
    .i_rword       (r_mem[w_idx]),
    .o_lane_en     (w_lane_en),
    .o_wdata_lanes (w_wdata_lanes),
    .o_rdata       (w_load_data),
    .o_misaligned  (w_misaligned)
  );

  // NOTE: the array has no reset branch so it maps onto plain RAM; the !reset term keeps a store from committing while reset is held.
  always_ff @(posedge clk) begin
    if (!reset && w_do_access && w_acc_we && !w_err) begin
      for (int i = 0; i < 4; i++) begin
        if (w_lane_en[i]) r_mem[w_idx][8*i +: 8] <= w_wdata_lanes[8*i +: 8];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_funct3 <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_we     <= req_we;
            r_addr   <= req_addr;
            r_funct3 <= req_funct3;
            r_wdata  <= req_wdata;
            r_cnt    <= CNT_INIT;
            r_state  <= (LATENCY == 1) ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (r_cnt == '0) r_state <= ST_RESP;
          else             r_cnt   <= r_cnt - CNT_W'(1);
        end
        ST_RESP: begin
          if (resp_ready) begin
            r_state <= ST_IDLE;
            r_rdata <= '0;
            r_err   <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
      if (w_do_access) begin
        r_rdata <= w_resp_data;
        r_err   <= w_err;
      end
    end
  end

  assign req_ready  = (r_state == ST_IDLE);
  assign resp_valid = (r_state == ST_RESP);
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

endmodule
